// File: rtl/dl_pulse.sv
// ---------------------------------------------------------------------------
// dl_pulse -- delay-line pulse stage
//
// On a rising edge of launch_DL this block waits `delay` ticks and then
// drives DL_out high for `width` ticks. Paired with the single-pulse
// generator that supplies launch_DL, it produces a double-pulse sequence.
// All timing advances only on cycles where `tick` is high, so everything
// runs on the one clock, clk_DL.
//
// Optional feature macro: DL_BURST_EN
//   defined   : the output becomes a burst of max(pulses,1) pulses separated
//               by max(gap,1) low ticks (adds the LOW state plus the gap and
//               remaining-pulse registers).
//   undefined : one pulse per launch; the gap and pulses inputs are ignored.
//
// Ports
//   clk_DL    in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   tick      in   time-base strobe; counters advance only when high
//   launch_DL in   rising edge starts a sequence, low aborts it
//   delay     in   ticks from launch to the first DL_out rise
//   width     in   DL_out high time in ticks (0 behaves as 1)
//   gap       in   low ticks between burst pulses (0 behaves as 1)
//   pulses    in   pulses per burst (0 behaves as 1)
//   DL_out    out  registered output pulse
//   busy      out  high while delaying or pulsing
//   done      out  high once the sequence has finished, until launch_DL drops
// ---------------------------------------------------------------------------
module dl_pulse #(
    parameter int CNT_W   = 17,
    parameter int BURST_W = 4
) (
    input  logic               clk_DL,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               launch_DL,
    input  logic [CNT_W-1:0]   delay,
    input  logic [CNT_W-1:0]   width,
    input  logic [CNT_W-1:0]   gap,
    input  logic [BURST_W-1:0] pulses,
    output logic               DL_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               launch_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   delay_l_q, delay_l_d;
    logic [CNT_W-1:0]   width_l_q, width_l_d;
    logic               dl_out_q, dl_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               rise;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   width_eff;

`ifdef DL_BURST_EN
    logic [CNT_W-1:0]   gap_l_q, gap_l_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]   gap_eff;

    assign gap_eff = (gap_l_q == '0) ? CNT_W'(1) : gap_l_q;
`else
    // Burst configuration has no function in the single-pulse build.
    logic unused_cfg;
    assign unused_cfg = ^{gap, pulses};
`endif

    assign rise      = launch_DL & ~launch_q;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign width_eff = (width_l_q == '0) ? CNT_W'(1) : width_l_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        delay_l_d = delay_l_q;
        width_l_d = width_l_q;
`ifdef DL_BURST_EN
        gap_l_d   = gap_l_q;
        rem_d     = rem_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Configuration is captured only here; later changes to the
                // inputs do not disturb a running sequence.
                if (rise) begin
                    delay_l_d = delay;
                    width_l_d = width;
`ifdef DL_BURST_EN
                    gap_l_d   = gap;
                    rem_d     = (pulses == '0) ? BURST_W'(1) : pulses;
`endif
                    cnt_d     = '0;
                    state_d   = (delay == '0) ? HIGH : DELAY;
                end
            end
            DELAY: begin
                if (!launch_DL) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (tick) begin
                    if (cnt_inc == delay_l_q) begin
                        cnt_d   = '0;
                        state_d = HIGH;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            HIGH: begin
                if (!launch_DL) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (tick) begin
                    if (cnt_inc == width_eff) begin
                        cnt_d = '0;
`ifdef DL_BURST_EN
                        if (rem_q > BURST_W'(1)) begin
                            rem_d   = rem_q - BURST_W'(1);
                            state_d = LOW;
                        end else begin
                            rem_d   = '0;
                            state_d = DONE;
                        end
`else
                        state_d = DONE;
`endif
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
`ifdef DL_BURST_EN
            LOW: begin
                if (!launch_DL) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (tick) begin
                    if (cnt_inc == gap_eff) begin
                        cnt_d   = '0;
                        state_d = HIGH;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
`endif
            DONE: begin
                // Hold here while launch_DL stays high so one launch level
                // can never produce a second sequence.
                if (!launch_DL) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state, so they change on the
        // same edge as the state itself.
        dl_out_d = (state_d == HIGH);
        busy_d   = (state_d == DELAY) || (state_d == HIGH) || (state_d == LOW);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk_DL or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            launch_q  <= 1'b0;
            cnt_q     <= '0;
            delay_l_q <= '0;
            width_l_q <= '0;
            dl_out_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            launch_q  <= launch_DL;
            cnt_q     <= cnt_d;
            delay_l_q <= delay_l_d;
            width_l_q <= width_l_d;
            dl_out_q  <= dl_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef DL_BURST_EN
    always_ff @(posedge clk_DL or negedge rst_n) begin
        if (!rst_n) begin
            gap_l_q <= '0;
            rem_q   <= '0;
        end else begin
            gap_l_q <= gap_l_d;
            rem_q   <= rem_d;
        end
    end
`endif

    assign DL_out = dl_out_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
